// File: rtl/led_share_if.sv
// led_share_if: bundle between the LED pattern sources and the LED share arbiter.
//   req   : per-source request levels
//   pat   : packed 4-bit patterns, source i at pat[4i+3:4i]
//   grant : one-hot current owner
//   busy  : arbiter is in GRANT
//   leds  : registered pattern of the owner
// master = pattern-source side, slave = arbiter side.
interface led_share_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   req;
  logic [4*N_REQ-1:0] pat;
  logic [N_REQ-1:0]   grant;
  logic               busy;
  logic [3:0]         leds;
  modport master (output req, pat, input grant, busy, leds);
  modport slave  (input req, pat, output grant, busy, leds);
endinterface

// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin sharing of the 4-bit LED bank with timed ownership slots.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : led_share_if slave (req/pat in, grant/busy/leds out)
module led_share_arbiter #(
  parameter int N_REQ      = 4,
  parameter int PRESCALE_W = 22,
  parameter int SLOT_TICKS = 4
) (
  input logic         clk,
  input logic         rst,
  led_share_if.slave  bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int SW = $clog2(SLOT_TICKS) + 1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
  logic [0:0]            state;
  logic [PRESCALE_W-1:0] prescaler;
  logic [SW-1:0]         slot_cnt;
  logic [IW-1:0]         last;
  logic [IW-1:0]         win;
  logic                  found;
  logic                  tick;
  logic                  expire;
  int                    j;
  assign tick   = &prescaler;
  assign expire = tick && slot_cnt == SW'(SLOT_TICKS - 1);
  // Scan last+1 .. last+N_REQ; in GRANT last is the owner, so the owner itself
  // is the final candidate and an expiry with no other requester regrants it.
  always_comb begin
    found = 1'b0;
    win   = last;
    j     = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(last) + k) % N_REQ;
      if (bus.req[j]) begin
        found = 1'b1;
        win   = IW'(j);
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prescaler <= '0;
      slot_cnt  <= '0;
      last      <= IW'(N_REQ - 1);
      bus.grant <= '0;
      bus.busy  <= 1'b0;
      bus.leds  <= '0;
    end else begin
      prescaler <= prescaler + PRESCALE_W'(1);
      if (state == IDLE) begin
        if (found) begin
          state     <= GRANT;
          bus.grant <= ONE << win;
          bus.busy  <= 1'b1;
          bus.leds  <= bus.pat[{win, 2'b00} +: 4];
          last      <= win;
          slot_cnt  <= '0;
        end else begin
          bus.leds  <= '0;
        end
      end else if (!bus.req[last]) begin
        state     <= IDLE;
        bus.grant <= '0;
        bus.busy  <= 1'b0;
        bus.leds  <= '0;
      end else if (expire) begin
        bus.grant <= ONE << win;
        bus.leds  <= bus.pat[{win, 2'b00} +: 4];
        last      <= win;
        slot_cnt  <= '0;
      end else begin
        bus.leds  <= bus.pat[{last, 2'b00} +: 4];
        slot_cnt  <= slot_cnt + SW'(tick);
      end
    end
  end
endmodule

// File: tb/tb_led_share_arbiter.sv
// tb_led_share_arbiter: directed and random checks of led_share_arbiter against a behavioural model.
module tb_led_share_arbiter;
  localparam int N  = 4;
  localparam int PW = 2;
  localparam int ST = 2;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   m_owner, m_last, m_slots, m_pc;
  logic [3:0] m_leds;
  always #5 clk = ~clk;
  led_share_if #(.N_REQ(N)) bus ();
  led_share_arbiter #(.N_REQ(N), .PRESCALE_W(PW), .SLOT_TICKS(ST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  function automatic int rr(int from, logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_slots = 0;
    m_pc    = 0;
    m_leds  = 4'h0;
  endtask
  function automatic bit next_tick();
    return (m_pc % (1 << PW)) == (1 << PW) - 1;
  endfunction
  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit t;
    t = next_tick();
    if (m_owner < 0) begin
      m_owner = rr(m_last, bus.req);
      if (m_owner >= 0) begin
        m_last  = m_owner;
        m_slots = 0;
      end
    end else if (!bus.req[m_owner]) begin
      m_owner = -1;
    end else if (t && m_slots == ST - 1) begin
      m_owner = rr(m_owner, bus.req);
      m_last  = m_owner;
      m_slots = 0;
    end else begin
      m_slots += int'(t);
    end
    m_leds = (m_owner < 0) ? 4'h0 : bus.pat[4*m_owner +: 4];
    m_pc++;
  endtask
  task automatic step();
    check("tick", 32'(dut.tick), 32'(next_tick()));
    model_edge();
    @(posedge clk);
    #1;
    check("grant", 32'(bus.grant), (m_owner < 0) ? 32'd0 : 32'(1 << m_owner));
    check("busy", 32'(bus.busy), 32'(m_owner >= 0));
    check("leds", 32'(bus.leds), 32'(m_leds));
  endtask
  initial begin
    int o;
    rst     = 1'b1;
    bus.req = '0;
    bus.pat = '0;
    #12;
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_leds", 32'(bus.leds), 32'd0);
    #4;
    rst = 1'b0;
    model_reset();
    repeat (20) step();
    bus.req = 4'b0001;
    bus.pat = 16'h000A;
    step();
    check("first_grant", 32'(bus.grant), 32'h1);
    check("first_leds", 32'(bus.leds), 32'hA);
    repeat (40) begin
      step();
      check("hold_grant", 32'(bus.grant), 32'h1);
    end
    bus.pat[3:0] = 4'h5;
    step();
    check("pat_follow", 32'(bus.leds), 32'h5);
    bus.req = 4'b1111;
    bus.pat = 16'h4321;
    repeat (48) begin
      step();
      check("no_gap", 32'(bus.busy), 32'h1);
    end
    for (int i = 0; i < 100 && m_owner != 1; i++) step();
    check("owner1_reached", 32'(bus.grant), 32'h2);
    bus.req = 4'b1101;
    step();
    check("drop_idle", 32'(bus.grant), 32'h0);
    check("drop_leds", 32'(bus.leds), 32'h0);
    step();
    check("drop_next", 32'(bus.grant), 32'h4);
    bus.req = 4'b1111;
    for (int i = 0; i < 100 && !(m_owner >= 0 && next_tick() && m_slots == ST - 1); i++) step();
    o = m_owner;
    check("expiry_reached", 32'(bus.busy), 32'h1);
    bus.req[o] = 1'b0;
    step();
    check("drop_on_expiry", 32'(bus.grant), 32'h0);
    step();
    check("rr_after_drop", 32'(bus.grant), 32'(1 << ((o + 1) % N)));
    bus.req = 4'b1111;
    for (int i = 0; i < 100 && m_owner != 2; i++) step();
    check("owner2_reached", 32'(bus.grant), 32'h4);
    #3;
    rst = 1'b1;
    #1;
    check("async_grant", 32'(bus.grant), 32'h0);
    check("async_busy", 32'(bus.busy), 32'h0);
    check("async_leds", 32'(bus.leds), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step();
    check("restart_src0", 32'(bus.grant), 32'h1);
    repeat (400) begin
      if ($urandom_range(3) == 0) bus.req = N'($urandom);
      if ($urandom_range(1) == 0) bus.pat = 16'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
